// File: rtl/load_store_unit.sv
// Initiator side of the 64-bit word-addressed data-memory interface.
// Byte/half/word/double loads and stores; sub-word stores use read-modify-write.
module load_store_unit #(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_address,
  output logic [63:0]       mem_writeData,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [63:0]       mem_readData
);

  // state   | meaning
  // IDLE    | waiting for a request, req_ready high
  // RD      | MemRead strobe for the addressed word
  // RD_WAIT | readData valid; extract load lanes or merge store lanes
  // WR      | MemWrite strobe with the full word
  // RESP    | one-cycle response pulse
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  localparam logic [ADDR_W-4:0] MEM_WORDS_IDX = (ADDR_W-3)'(MEM_WORDS);

  state_t state, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              store_q;
  logic              uns_q;
  logic [63:0]       wdata_q;
  logic [63:0]       wr_word_q;
  logic [63:0]       result_q;
  logic              mis_q;
  logic              fault_q;

  logic        accept;
  logic        mis_c;
  logic        fault_c;
  logic [5:0]  sh;
  logic [63:0] lane;
  logic [63:0] load_ext;
  logic [63:0] mask;
  logic [63:0] merged;

  assign accept  = req_valid && (state == IDLE);
  assign fault_c = req_addr[ADDR_W-1:3] >= MEM_WORDS_IDX;

  always_comb begin
    mis_c = 1'b0;
    case (req_size)
      2'b01:   mis_c = req_addr[0];
      2'b10:   mis_c = |req_addr[1:0];
      2'b11:   mis_c = |req_addr[2:0];
      default: mis_c = 1'b0;
    endcase
  end

  // Little-endian lanes: shift the addressed lane down to bit 0.
  assign sh   = {addr_q[2:0], 3'b000};
  assign lane = mem_readData >> sh;

  always_comb begin
    load_ext = lane;
    mask     = '1;
    case (size_q)
      2'b00: begin
        load_ext = uns_q ? {56'd0, lane[7:0]} : {{56{lane[7]}}, lane[7:0]};
        mask     = 64'h0000_0000_0000_00FF;
      end
      2'b01: begin
        load_ext = uns_q ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
        mask     = 64'h0000_0000_0000_FFFF;
      end
      2'b10: begin
        load_ext = uns_q ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
        mask     = 64'h0000_0000_FFFF_FFFF;
      end
      default: begin
        load_ext = lane;
        mask     = '1;
      end
    endcase
  end

  assign merged = (mem_readData & ~(mask << sh)) | ((wdata_q & mask) << sh);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mis_c || fault_c)                    state_d = RESP;
          else if (req_is_store && req_size == 2'b11) state_d = WR;
          else                                     state_d = RD;
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: state_d = store_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      size_q    <= '0;
      store_q   <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      result_q  <= '0;
      mis_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else if (accept) begin
      addr_q    <= req_addr;
      size_q    <= req_size;
      store_q   <= req_is_store;
      uns_q     <= req_unsigned;
      wdata_q   <= req_wdata;
      wr_word_q <= req_wdata;
      result_q  <= '0;
      mis_q     <= mis_c;
      fault_q   <= !mis_c && fault_c;
    end else if (state == RD_WAIT) begin
      if (store_q) wr_word_q <= merged;
      else         result_q  <= load_ext;
    end
  end

  assign req_ready       = (state == IDLE);
  assign resp_valid      = (state == RESP);
  assign resp_rdata      = resp_valid ? result_q : '0;
  assign resp_misaligned = resp_valid && mis_q;
  assign resp_fault      = resp_valid && fault_q;
  assign mem_MemRead     = (state == RD);
  assign mem_MemWrite    = (state == WR);
  assign mem_writeData   = mem_MemWrite ? wr_word_q : '0;
  assign mem_address     = (state == RD || state == RD_WAIT || state == WR)
                         ? {addr_q[ADDR_W-1:3], 3'b000} : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios then random requests, checked
// against a byte-array reference memory.
module tb_load_store_unit;
  localparam int MEM_WORDS = 32;
  localparam int ADDR_W    = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_misaligned;
  logic              resp_fault;
  logic [ADDR_W-1:0] mem_address;
  logic [63:0]       mem_writeData;
  logic              mem_MemWrite;
  logic              mem_MemRead;
  logic [63:0]       mem_readData;

  int nvec = 0;
  int nmis = 0;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_readData(mem_readData)
  );

  always #5 clk = ~clk;

  // Data memory the unit talks to.
  logic [63:0] mem [MEM_WORDS];
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 64'(i);
    mem_readData = '0;
  end
  always @(posedge clk) begin
    if (mem_MemWrite) mem[mem_address[7:3]] <= mem_writeData;
    if (mem_MemRead)  mem_readData <= mem[mem_address[7:3]];
  end

  // Reference model: flat byte array.
  byte unsigned ref_bytes [MEM_WORDS*8];
  initial for (int i = 0; i < MEM_WORDS*8; i++) ref_bytes[i] = (i % 8 == 0) ? 8'(i / 8) : 8'd0;

  function automatic logic [63:0] ref_word(input longint unsigned widx);
    logic [63:0] v = '0;
    for (int k = 0; k < 8; k++) v = v + (64'(ref_bytes[widx*8+k]) << (8*k));
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input bit st, input logic [1:0] sz, input bit un,
                         input logic [63:0] a, input logic [63:0] wd);
    int nb = 1 << sz;
    bit mis = (a % nb) != 0;
    bit flt = !mis && ((a >> 3) >= MEM_WORDS);
    logic [63:0] exp_rd = '0;
    logic [63:0] exp_ww = '0;
    int exp_lat, exp_rds, exp_wrs;
    int lat = 0, rds = 0, wrs = 0, rdy = 0, waitc = 0;
    logic [63:0] got_rd = '0, got_ww = '0, got_wa = '0;
    logic got_mis = 1'b0, got_flt = 1'b0;

    if (!mis && !flt) begin
      if (st) begin
        for (int k = 0; k < nb; k++) ref_bytes[a+k] = 8'(wd >> (8*k));
        exp_ww = ref_word(a >> 3);
      end else begin
        for (int k = 0; k < nb; k++) exp_rd = exp_rd + (64'(ref_bytes[a+k]) << (8*k));
        if (!un && nb < 8 && exp_rd[8*nb-1]) exp_rd = exp_rd - (64'd1 << (8*nb));
      end
    end
    exp_lat = (mis || flt) ? 1 : (!st ? 3 : (sz == 2'b11 ? 2 : 4));
    exp_rds = (mis || flt || (st && sz == 2'b11)) ? 0 : 1;
    exp_wrs = (st && !mis && !flt) ? 1 : 0;

    while (!req_ready && waitc < 20) begin @(negedge clk); waitc++; end
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_is_store = $urandom_range(0, 1) == 1;
    req_size = 2'($urandom); req_unsigned = $urandom_range(0, 1) == 1;
    req_addr = {32'd0, $urandom}; req_wdata = {$urandom, $urandom};
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_MemRead) rds++;
      if (mem_MemWrite) begin wrs++; got_ww = mem_writeData; got_wa = mem_address; end
      if (req_ready) rdy++;
      if (resp_valid) begin
        lat = c; got_rd = resp_rdata; got_mis = resp_misaligned; got_flt = resp_fault;
        break;
      end
    end
    check($sformatf("latency a=%0h", a), 64'(lat), 64'(exp_lat));
    check($sformatf("rdata a=%0h", a), got_rd, exp_rd);
    check($sformatf("misaligned a=%0h", a), 64'(got_mis), 64'(mis));
    check($sformatf("fault a=%0h", a), 64'(got_flt), 64'(flt));
    check($sformatf("read_strobes a=%0h", a), 64'(rds), 64'(exp_rds));
    check($sformatf("write_strobes a=%0h", a), 64'(wrs), 64'(exp_wrs));
    check($sformatf("busy_ready a=%0h", a), 64'(rdy), 64'd0);
    if (exp_wrs == 1) begin
      check($sformatf("write_data a=%0h", a), got_ww, exp_ww);
      check($sformatf("write_addr a=%0h", a), got_wa, {a[63:3], 3'b000});
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_rdata"}, resp_rdata, 64'd0);
    check({tag, "_flags"}, {62'd0, resp_misaligned, resp_fault}, 64'd0);
    check({tag, "_strobes"}, {62'd0, mem_MemRead, mem_MemWrite}, 64'd0);
    check({tag, "_mem_address"}, mem_address, 64'd0);
    check({tag, "_mem_writeData"}, mem_writeData, 64'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'b11;
    req_unsigned = 1'b0; req_addr = 64'h8; req_wdata = '1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    run_req(0, 2'b11, 0, 64'h18, 64'd0);                  // ld 0x18 -> 3
    run_req(1, 2'b11, 0, 64'h08, 64'h1122334455667788);   // sd
    run_req(0, 2'b11, 0, 64'h08, 64'd0);                  // ld
    run_req(0, 2'b01, 0, 64'h0E, 64'd0);                  // lh
    run_req(0, 2'b00, 1, 64'h0F, 64'd0);                  // lbu
    run_req(1, 2'b00, 0, 64'h21, 64'h80);                 // sb -> 0x8004
    run_req(0, 2'b00, 0, 64'h21, 64'd0);                  // lb
    run_req(0, 2'b00, 1, 64'h21, 64'd0);                  // lbu
    run_req(0, 2'b10, 0, 64'h22, 64'd0);                  // lw misaligned
    run_req(1, 2'b01, 0, 64'h23, 64'hFFFF);               // sh misaligned
    run_req(0, 2'b11, 0, 64'h100, 64'd0);                 // fault
    run_req(0, 2'b11, 0, 64'hF8, 64'd0);                  // last word

    // Reset during RD_WAIT of a lw aborts it.
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 64'h20; req_wdata = '0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1 check_idle_outputs("abort");
    @(negedge clk);
    check_idle_outputs("abort_hold");
    reset = 1'b0;
    @(negedge clk);
    check("abort_no_resp", 64'(resp_valid), 64'd0);
    run_req(0, 2'b11, 0, 64'h10, 64'd0);                  // ld 0x10 -> 2

    for (int i = 0; i < 80; i++) begin
      logic [1:0] sz = 2'($urandom);
      logic [63:0] a = 64'($urandom_range(0, MEM_WORDS*8 + 15));
      run_req($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1, a,
              {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
